dice_roller: RTL and testbench
==============================

# dice_roller

Parametrised multi-die electronic dice. N_DICE dice, each counting 1..FACES, chained as an odometer while the roll button is held. Dice can be individually held. When the button is released, the block registers the dice total and pulses a one-cycle `valid`. It is the next generation of the single-die `dice` block and sits between the debounced button input and the display/score logic.

## Interface
- `N_DICE`, default 2: number of dice, 1..8.
- `FACES`, default 6: faces per die, 2..(2**FACE_W − 1).
- `FACE_W`, default 3: bits per die value.
- `SUM_W`, default 4: total width; must hold N_DICE*FACES.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `button`  in  1  roll request; dice advance on every edge where it is sampled 1.
- `hold`  in  N_DICE  per-die freeze; a held die keeps its value.
- `throw`  out  N_DICE*FACE_W  die k occupies bits [k*FACE_W +: FACE_W].
- `sum`  out  SUM_W  registered total of all dice at settle.
- `valid`  out  1  one-cycle pulse when `sum` is updated.
- `doubles`  out  1  only present with DICE_DOUBLES_EN (see Configuration).

## Operation
- **Reset:** `throw` = all zeros, `sum` = 0, `valid` = 0, `doubles` = 0, FSM = IDLE. Reset overrides all other inputs.
- **Illegal correction:** a die holding 0 or a value > FACES loads 1 on the next edge.
  - Takes priority over `hold` and `button`.
  - A corrected die generates no carry.
- **Carry chain:**
  - carry_0 = 1.
  - carry_(k+1) = carry_k & (hold[k] | die_k == FACES).
- **Advance:** die k advances when `button` & ~`hold[k]` & carry_k & the die is legal.
  - Advance is FACES → 1, otherwise +1.
  - A held die passes the carry through unchanged.
- **FSM states:** IDLE, ROLL, SETTLE.
  - IDLE: `button`=1 → ROLL.
  - ROLL: `button`=0 → SETTLE.
  - SETTLE: → ROLL if `button`=1, otherwise → IDLE.
  - Leaving SETTLE (either way): `sum` ← sum of current dice, `valid` ← 1.
- **`valid`:** high for exactly one cycle per SETTLE, and 0 in every other state.
- **`sum`:** holds its value until the next settle or reset.
- **Arithmetic:** the total is computed at SUM_W bits, zero-extended per die. There is no overflow within the legal parameter range.
- **Held dice:** `hold` changes take effect at the next edge and do not affect FSM state.

## Timing
- Button sampled 1 at edge t: `throw` shows the advanced values after t. Latency is 1 cycle.
- Button sampled 0 at edge t while in ROLL:
  - `throw` is frozen from t.
  - SETTLE holds during cycle t..t+1.
  - `sum`/`valid` become visible after edge t+1.
  - `valid` falls after t+2.
- First edge after reset release: every die is corrected 0 → 1. No `valid` pulse.
- Reset asserted mid-ROLL or mid-SETTLE: outputs return to reset values after that edge, and no `valid` pulse is produced.
- Full odometer period with no holds is FACES**N_DICE cycles of `button`=1.

## Configuration
- Macro: `DICE_DOUBLES_EN`.
- **Defined:**
  - Output `doubles` exists.
  - It is registered alongside `sum` and is 1 iff all non-held dice are equal at settle, else 0.
  - It holds its value until the next settle and is 0 on reset.
  - If every die is held, `doubles` = 0.
- **Undefined:** the `doubles` port and its logic are absent; all other behaviour is identical.

## Test plan
1. **Reset and correction.** `rst`=1 for 3 cycles → `throw`=0, `sum`=0, `valid`=0. Release `rst` → after 1 edge, `throw` = {1,1}.
2. **Roll with wrap.** Start {d1,d0}={1,1}, `button`=1 for 7 cycles → d0 steps 2,3,4,5,6,1,2 and d1 steps to 2 on the wrap; final {2,2}. Drop `button` → `sum`=4 and `valid`=1 for one cycle, 2 edges after release.
3. **Hold.** `hold`=2'b01 from {1,1}, `button`=1 for 3 cycles → {4,1}. Settle → `sum`=5.
4. **Reset mid-roll.** `rst`=1 while `button`=1 in ROLL → `throw`=0, `valid` stays 0, FSM is IDLE, and the next press restarts from corrected {1,1}.
5. **Full period.** `button`=1 for 36 cycles from {1,1} → back to {1,1}. Settle → `sum`=2, `valid` pulses once.
6. **Doubles (DICE_DOUBLES_EN defined).** Settle at {2,2} → `doubles`=1 with `valid`. Then settle at {3,2} → `doubles`=0.

Source files
------------

// File: rtl/dice_roller.sv
// Multi-die electronic dice: N_DICE dice chained as an odometer while button is held,
// registered total with a one-cycle valid on release. Optional `doubles` output under DICE_DOUBLES_EN.
module dice_roller #(
  parameter int unsigned N_DICE = 2,
  parameter int unsigned FACES  = 6,
  parameter int unsigned FACE_W = 3,
  parameter int unsigned SUM_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       button,
  input  logic [N_DICE-1:0]          hold,
  output logic [N_DICE*FACE_W-1:0]   throw,
  output logic [SUM_W-1:0]           sum,
  output logic                       valid
`ifdef DICE_DOUBLES_EN
  ,
  output logic                       doubles
`endif
);

  localparam int unsigned THROW_W = N_DICE * FACE_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROLL   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [THROW_W-1:0] throw_q, throw_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               valid_q, valid_d;

  logic [FACE_W-1:0]  cur;
  logic               legal;
  logic               carry;
  logic [SUM_W-1:0]   total;

  // Odometer advance with illegal-value correction; a corrected die breaks the carry.
  always_comb begin
    throw_d = throw_q;
    cur     = '0;
    legal   = 1'b0;
    carry   = 1'b1;
    total   = '0;
    for (int k = 0; k < int'(N_DICE); k++) begin
      cur   = throw_q[k*FACE_W +: FACE_W];
      legal = (cur != '0) && (cur <= FACE_W'(FACES));
      total = total + SUM_W'(cur);
      if (!legal) begin
        throw_d[k*FACE_W +: FACE_W] = FACE_W'(1);
      end else if (button && !hold[k] && carry) begin
        throw_d[k*FACE_W +: FACE_W] = (cur == FACE_W'(FACES)) ? FACE_W'(1) : cur + FACE_W'(1);
      end
      carry = carry && legal && (hold[k] || (cur == FACE_W'(FACES)));
    end
  end

  // Roll/settle sequencing; the total is captured on leaving SETTLE.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (button) state_d = ST_ROLL;
      end
      ST_ROLL: begin
        if (!button) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = button ? ST_ROLL : ST_IDLE;
        sum_d   = total;
        valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      throw_q <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      throw_q <= throw_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign throw = throw_q;
  assign sum   = sum_q;
  assign valid = valid_q;

`ifdef DICE_DOUBLES_EN
  logic               doubles_q, doubles_d;
  logic [FACE_W-1:0]  ref_val;
  logic               any_free;
  logic               all_eq;

  // Doubles: every non-held die shows the same face; all-held never counts.
  always_comb begin
    doubles_d = doubles_q;
    ref_val   = '0;
    any_free  = 1'b0;
    all_eq    = 1'b1;
    for (int k = 0; k < int'(N_DICE); k++) begin
      if (!hold[k]) begin
        if (!any_free) begin
          ref_val  = throw_q[k*FACE_W +: FACE_W];
          any_free = 1'b1;
        end else if (throw_q[k*FACE_W +: FACE_W] != ref_val) begin
          all_eq = 1'b0;
        end
      end
    end
    if (state_q == ST_SETTLE) doubles_d = any_free && all_eq;
  end

  always_ff @(posedge clk) begin
    if (rst) doubles_q <= 1'b0;
    else     doubles_q <= doubles_d;
  end

  assign doubles = doubles_q;
`endif

endmodule

// File: tb/tb_dice_roller.sv
// Directed self-checking bench for dice_roller at default parameters (2 dice, 6 faces).
module tb_dice_roller;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [1:0] hold;
  logic [5:0] throw_w;
  logic [3:0] sum_w;
  logic       valid_w;
`ifdef DICE_DOUBLES_EN
  logic       doubles_w;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dice_roller dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .hold   (hold),
    .throw  (throw_w),
    .sum    (sum_w),
    .valid  (valid_w)
`ifdef DICE_DOUBLES_EN
    ,
    .doubles(doubles_w)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset then release with button low: dice corrected to {1,1}, FSM idle.
  task automatic do_reset();
    rst = 1'b1; button = 1'b0; hold = 2'b00;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; hold = 2'b00;
    repeat (3) step();
    n_cmp++;
    if (throw_w !== 6'o00 || sum_w !== 4'd0 || valid_w !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: throw=%o sum=%0d valid=%b required throw=00 sum=0 valid=0", throw_w, sum_w, valid_w);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (throw_w !== 6'o11 || valid_w !== 1'b0) begin
      n_err++;
      $display("FAIL reset_correction: throw=%o valid=%b required throw=11 valid=0", throw_w, valid_w);
    end
  endtask

  task automatic test_roll_wrap();
    int exp_d0 [7] = '{2, 3, 4, 5, 6, 1, 2};
    button = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++;
      if (throw_w[2:0] !== 3'(exp_d0[i])) begin
        n_err++;
        $display("FAIL roll_d0_step%0d: d0=%0d required %0d", i, throw_w[2:0], exp_d0[i]);
      end
    end
    n_cmp++;
    if (throw_w !== 6'o22) begin
      n_err++;
      $display("FAIL roll_final: throw=%o required 22", throw_w);
    end
    button = 1'b0;
    step();
    n_cmp++;
    if (valid_w !== 1'b0 || throw_w !== 6'o22) begin
      n_err++;
      $display("FAIL roll_settle_t: valid=%b throw=%o required valid=0 throw=22", valid_w, throw_w);
    end
    step();
    n_cmp++;
    if (valid_w !== 1'b1 || sum_w !== 4'd4) begin
      n_err++;
      $display("FAIL roll_sum: valid=%b sum=%0d required valid=1 sum=4", valid_w, sum_w);
    end
`ifdef DICE_DOUBLES_EN
    n_cmp++;
    if (doubles_w !== 1'b1) begin
      n_err++;
      $display("FAIL doubles_22: doubles=%b required 1", doubles_w);
    end
`endif
    step();
    n_cmp++;
    if (valid_w !== 1'b0 || sum_w !== 4'd4) begin
      n_err++;
      $display("FAIL roll_valid_fall: valid=%b sum=%0d required valid=0 sum=4", valid_w, sum_w);
    end
  endtask

  task automatic test_hold();
    do_reset();
    hold = 2'b01; button = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (throw_w !== 6'o41) begin
      n_err++;
      $display("FAIL hold_throw: throw=%o required 41", throw_w);
    end
    button = 1'b0;
    step();
    step();
    n_cmp++;
    if (valid_w !== 1'b1 || sum_w !== 4'd5) begin
      n_err++;
      $display("FAIL hold_sum: valid=%b sum=%0d required valid=1 sum=5", valid_w, sum_w);
    end
`ifdef DICE_DOUBLES_EN
    n_cmp++;
    if (doubles_w !== 1'b1) begin
      n_err++;
      $display("FAIL doubles_single_free: doubles=%b required 1", doubles_w);
    end
`endif
    hold = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_roll();
    do_reset();
    button = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (throw_w !== 6'o00 || valid_w !== 1'b0 || sum_w !== 4'd0) begin
      n_err++;
      $display("FAIL reset_mid_roll: throw=%o valid=%b sum=%0d required 00/0/0", throw_w, valid_w, sum_w);
    end
    // Reset landing while in SETTLE must swallow the pending valid.
    rst = 1'b0; button = 1'b0;
    step();
    button = 1'b1;
    step();
    button = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (valid_w !== 1'b0 || sum_w !== 4'd0 || throw_w !== 6'o11) begin
      n_err++;
      $display("FAIL reset_mid_settle: valid=%b sum=%0d throw=%o required 0/0/11", valid_w, sum_w, throw_w);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; button = 1'b1;
    step();
    n_cmp++;
    if (throw_w !== 6'o11) begin
      n_err++;
      $display("FAIL restart_corrected: throw=%o required 11", throw_w);
    end
    step();
    n_cmp++;
    if (throw_w !== 6'o12) begin
      n_err++;
      $display("FAIL restart_advance: throw=%o required 12", throw_w);
    end
    button = 1'b0;
    step();
    step();
    n_cmp++;
    if (valid_w !== 1'b1 || sum_w !== 4'd3) begin
      n_err++;
      $display("FAIL restart_sum: valid=%b sum=%0d required valid=1 sum=3", valid_w, sum_w);
    end
    step();
  endtask

  task automatic test_full_period();
    int pulses = 0;
    do_reset();
    button = 1'b1;
    repeat (18) step();
    n_cmp++;
    if (throw_w !== 6'o41) begin
      n_err++;
      $display("FAIL period_half: throw=%o required 41", throw_w);
    end
    repeat (18) step();
    n_cmp++;
    if (throw_w !== 6'o11) begin
      n_err++;
      $display("FAIL period_full: throw=%o required 11", throw_w);
    end
    button = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (valid_w === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || sum_w !== 4'd2) begin
      n_err++;
      $display("FAIL period_settle: pulses=%0d sum=%0d required pulses=1 sum=2", pulses, sum_w);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    button = 1'b1;
    repeat (13) step();
    n_cmp++;
    if (throw_w !== 6'o32) begin
      n_err++;
      $display("FAIL b2b_throw: throw=%o required 32", throw_w);
    end
    button = 1'b0;
    step();
    step();
    n_cmp++;
    if (valid_w !== 1'b1 || sum_w !== 4'd5) begin
      n_err++;
      $display("FAIL b2b_sum: valid=%b sum=%0d required valid=1 sum=5", valid_w, sum_w);
    end
`ifdef DICE_DOUBLES_EN
    n_cmp++;
    if (doubles_w !== 1'b0) begin
      n_err++;
      $display("FAIL doubles_32: doubles=%b required 0", doubles_w);
    end
`endif
    // Everything held: dice frozen, a new settle reports the same total.
    hold = 2'b11; button = 1'b1;
    step();
    button = 1'b0;
    step();
    step();
    n_cmp++;
    if (valid_w !== 1'b1 || sum_w !== 4'd5 || throw_w !== 6'o32) begin
      n_err++;
      $display("FAIL all_held: valid=%b sum=%0d throw=%o required 1/5/32", valid_w, sum_w, throw_w);
    end
`ifdef DICE_DOUBLES_EN
    n_cmp++;
    if (doubles_w !== 1'b0) begin
      n_err++;
      $display("FAIL doubles_all_held: doubles=%b required 0", doubles_w);
    end
`endif
    hold = 2'b00;
    step();
  endtask

  initial begin
    rst = 1'b1; button = 1'b0; hold = 2'b00;
    test_reset();
    test_roll_wrap();
    test_hold();
    test_reset_mid_roll();
    test_full_period();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
